rgmii_tx_framer: RTL and testbench

//  Transmit-side counterpart of the RGMII receive path. Accepts a frame as a byte stream on clk125MHz,

---
 rtl/rgmii_tx_framer.sv | 176 +++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: byte stream in, preamble/SFD/pad/FCS/IFG framing out,
// registered per-edge nibble and control values for the ODDR stage.
module rgmii_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       clk125MHz,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [3:0] txd_r,
  output logic [3:0] txd_f,
  output logic       txctl_r,
  output logic       txctl_f,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  FCS_LAST = 8'd3;
  // The single IDLE cycle before the next preamble completes the gap,
  // so the IFG state itself lasts one byte-time less than IFG_BYTES.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 2);
  localparam logic [16:0] MIN_P    = 17'(MIN_PAYLOAD);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [15:0] byte_cnt;
  logic [16:0] cnt_plus;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic        tx_er;
  logic        underrun_next;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_plus = {1'b0, byte_cnt} + 17'd1;
  assign fcs_word = ~crc;

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    tx_byte       = '0;
    tx_en         = 1'b0;
    tx_er         = 1'b0;
    underrun_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) state_next = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        tx_byte = 8'h55;
        tx_en   = 1'b1;
        if (cnt == PRE_LAST) state_next = ST_SFD;
      end
      ST_SFD: begin
        tx_byte    = 8'hD5;
        tx_en      = 1'b1;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_en = 1'b1;
        if (s_valid) begin
          tx_byte = s_data;
          tx_er   = s_err;
          if (s_last) state_next = (cnt_plus < MIN_P) ? ST_PAD : ST_FCS;
        end else begin
          tx_er         = 1'b1;
          underrun_next = 1'b1;
          state_next    = ST_IFG;
        end
      end
      ST_PAD: begin
        tx_en = 1'b1;
        if (cnt_plus == MIN_P) state_next = ST_FCS;
      end
      ST_FCS: begin
        tx_en   = 1'b1;
        tx_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
        if (cnt == FCS_LAST) state_next = ST_IFG;
      end
      ST_IFG: begin
        if (cnt == IFG_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shared per-state cycle counter (preamble, FCS, IFG); restarts on every state change.
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= '1;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_SFD: begin
          crc      <= '1;
          byte_cnt <= '0;
        end
        ST_DATA: begin
          if (s_valid) begin
            crc      <= crc32_byte(crc, s_data);
            byte_cnt <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 16'd1;
          end
        end
        ST_PAD: begin
          crc      <= crc32_byte(crc, 8'h00);
          byte_cnt <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      txd_r    <= '0;
      txd_f    <= '0;
      txctl_r  <= 1'b0;
      txctl_f  <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      txd_r    <= tx_byte[3:0];
      txd_f    <= tx_byte[7:4];
      txctl_r  <= tx_en;
      txctl_f  <= tx_en ^ tx_er;
      s_ready  <= (state_next == ST_DATA);
      busy     <= (state_next != ST_IDLE);
      underrun <= underrun_next;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: frame table plus back-to-back and
// reset-during-pad sequences, with a reference CRC32 and wire-byte model.
module tb_rgmii_tx_framer;

  logic       clk125MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_err = 1'b0;
  logic       s_ready;
  logic [3:0] txd_r;
  logic [3:0] txd_f;
  logic       txctl_r;
  logic       txctl_f;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  always #4 clk125MHz = ~clk125MHz;

  rgmii_tx_framer #(
    .PREAMBLE_LEN(7),
    .MIN_PAYLOAD (60),
    .IFG_BYTES   (12)
  ) dut (
    .clk125MHz(clk125MHz),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_err    (s_err),
    .s_ready  (s_ready),
    .txd_r    (txd_r),
    .txd_f    (txd_f),
    .txctl_r  (txctl_r),
    .txctl_f  (txctl_f),
    .busy     (busy),
    .underrun (underrun)
  );

  typedef struct {
    int         len;
    logic [7:0] first;
    int         err_pos;
    int         stop_at;
    int         exp_en;
    int         exp_ready;
    int         exp_under;
    int         exp_pad;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
      else      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  task automatic run_frame(input int vn, input vec_t v);
    logic [7:0] wire_q[$];
    logic       er_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [31:0] crc;
    int idx, en_cnt, rdy_cnt, und_cnt, dirty, n, pay;
    bit started, done, acc, under_case, er_exp;

    idx = 0; en_cnt = 0; rdy_cnt = 0; und_cnt = 0; dirty = 0;
    started = 0; done = 0;
    under_case = (v.stop_at >= 0);
    s_data  = v.first;
    s_last  = (v.len == 1);
    s_err   = (v.err_pos == 0);
    s_valid = 1'b1;

    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk125MHz);
      if (txctl_r) begin
        wire_q.push_back({txd_f, txd_r});
        er_q.push_back(!txctl_f);
        en_cnt++;
      end else if (txctl_f || txd_r != 4'h0 || txd_f != 4'h0) begin
        dirty++;
      end
      if (s_ready) rdy_cnt++;
      if (underrun) und_cnt++;
      if (busy) started = 1;
      else if (started) done = 1;
      acc = s_valid && s_ready;
      @(posedge clk125MHz);
      #1;
      if (acc) begin
        idx++;
        if (idx == v.len || idx == v.stop_at) begin
          s_valid = 1'b0;
          s_last  = 1'b0;
          s_err   = 1'b0;
        end else begin
          s_data = v.first + 8'(idx);
          s_last = (idx == v.len - 1);
          s_err  = (idx == v.err_pos);
        end
      end
    end

    check($sformatf("v%0d_done", vn), done, 1);
    check($sformatf("v%0d_en_cycles", vn), en_cnt, v.exp_en);
    check($sformatf("v%0d_ready_cycles", vn), rdy_cnt, v.exp_ready);
    check($sformatf("v%0d_underrun_pulses", vn), und_cnt, v.exp_under);
    check($sformatf("v%0d_idle_clean", vn), dirty, 0);

    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    if (under_case) begin
      for (int i = 0; i < v.stop_at; i++) exp_q.push_back(v.first + 8'(i));
      exp_q.push_back(8'h00);
    end else begin
      crc = 32'hFFFF_FFFF;
      pay = (v.len < 60) ? 60 : v.len;
      for (int i = 0; i < pay; i++) begin
        b = (i < v.len) ? v.first + 8'(i) : 8'h00;
        exp_q.push_back(b);
        crc = ref_crc(crc, b);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
      check($sformatf("v%0d_pad_bytes", vn), wire_q.size() - 12 - v.len, v.exp_pad);
      crc = 32'hFFFF_FFFF;
      for (int k = 8; k < wire_q.size(); k++) crc = ref_crc(crc, wire_q[k]);
      check($sformatf("v%0d_crc_residue", vn), bitrev32(crc), 32'hC704_DD7B);
    end

    check($sformatf("v%0d_wire_len", vn), wire_q.size(), exp_q.size());
    n = (wire_q.size() < exp_q.size()) ? wire_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("v%0d_byte%0d", vn, k), wire_q[k], exp_q[k]);
      er_exp = (v.err_pos >= 0 && k == 8 + v.err_pos) || (under_case && k == exp_q.size() - 1);
      check($sformatf("v%0d_er%0d", vn, k), er_q[k], er_exp);
    end
  endtask

  initial begin
    bit got, done, acc, prev_en;
    int en_total, falls, gap, busy_low, idx;

    vecs[0] = '{1,  8'hAB, -1, -1, 72, 1,  0, 59};
    vecs[1] = '{64, 8'h00, -1, -1, 76, 64, 0, 0};
    vecs[2] = '{20, 8'h40, -1, 10, 19, 11, 1, 0};
    vecs[3] = '{30, 8'h10, 5,  -1, 72, 30, 0, 30};
    vecs[4] = '{60, 8'h80, -1, -1, 72, 60, 0, 0};
    vecs[5] = '{59, 8'hC0, -1, -1, 72, 59, 0, 1};
    vecs[6] = '{61, 8'hE0, 0,  -1, 73, 61, 0, 0};

    repeat (3) @(negedge clk125MHz);
    check("rst_txctl_r", txctl_r, 0);
    check("rst_txctl_f", txctl_f, 0);
    check("rst_txd", {txd_f, txd_r}, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk125MHz);
    check("idle_txctl_r", txctl_r, 0);
    check("idle_busy", busy, 0);

    for (int v = 0; v < 7; v++) run_frame(v, vecs[v]);

    // Back-to-back: s_valid held across two one-byte frames.
    idx = 0; en_total = 0; falls = 0; gap = 0; busy_low = 0; prev_en = 0; done = 0;
    s_data = 8'h11; s_last = 1'b1; s_err = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk125MHz);
      if (txctl_r) en_total++;
      if (prev_en && !txctl_r) falls++;
      if (falls == 1 && !txctl_r) gap++;
      if (falls == 1 && !busy) busy_low++;
      if (falls == 2 && !busy) done = 1;
      prev_en = txctl_r;
      acc = s_valid && s_ready;
      @(posedge clk125MHz);
      #1;
      if (acc) begin
        idx++;
        if (idx == 2) begin
          s_valid = 1'b0;
          s_last  = 1'b0;
        end else begin
          s_data = 8'h22;
        end
      end
    end
    check("b2b_done", done, 1);
    check("b2b_en_total", en_total, 144);
    check("b2b_idle_gap", gap, 12);
    check("b2b_busy_low", busy_low, 1);

    // Asynchronous reset while padding a short frame.
    s_data = 8'hAB; s_last = 1'b1; s_err = 1'b0; s_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk125MHz);
      if (s_ready) got = 1;
    end
    check("rstpad_ready_seen", got, 1);
    @(posedge clk125MHz);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (20) @(negedge clk125MHz);
    check("rstpad_pre_en", txctl_r, 1);
    check("rstpad_pre_txd", {txd_f, txd_r}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstpad_txctl_r", txctl_r, 0);
    check("rstpad_txctl_f", txctl_f, 0);
    check("rstpad_txd", {txd_f, txd_r}, 0);
    check("rstpad_busy", busy, 0);
    @(negedge clk125MHz);
    rst_n = 1'b1;
    @(negedge clk125MHz);
    run_frame(7, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
